// File: rtl/ext_pipe_if.sv
// Handshake bundle between decode and the immediate extender: request side in_*, result side out_*.
// slave is the extender's view; master is the decode/consumer view.
interface ext_pipe_if #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [IMM_W-1:0]         imm;
  logic [2:0]               ext_op;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_valid, imm, ext_op, out_ready,
    output in_ready, out_valid, out_data, out_illegal, count
  );

  modport master (
    output in_valid, imm, ext_op, out_ready,
    input  in_ready, out_valid, out_data, out_illegal, count
  );
endinterface

// File: rtl/ext_pipe.sv
// Buffered immediate extender: extends at the input, queues results in a DEPTH-entry in-order FIFO.
// Latency 1 cycle, 1 entry/cycle; in_ready = !full (no same-cycle pop bypass), out_valid = !empty.
module ext_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_vld,
  output logic                    wr_rdy,
  input  logic [WIDTH-1:0]        wr_dat,
  output logic                    rd_vld,
  input  logic                    rd_rdy,
  output logic [WIDTH-1:0]        rd_dat,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign wr_rdy = (count_q != CNT_W'(DEPTH));
  assign rd_vld = (count_q != '0);
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  ext_pipe_if.slave   bus
);
  localparam int EXT_W = OUT_W - IMM_W;

  typedef struct packed {
    logic             illegal;
    logic [OUT_W-1:0] data;
  } entry_t;

  entry_t           in_ent;
  entry_t           head;
  logic [OUT_W-1:0] sext;

  always_comb begin
    sext           = {{EXT_W{bus.imm[IMM_W-1]}}, bus.imm};
    in_ent.illegal = 1'b0;
    in_ent.data    = '0;
    case (bus.ext_op)
      3'b000:  in_ent.data = {{EXT_W{1'b0}}, bus.imm};
      3'b001:  in_ent.data = sext;
      3'b010:  in_ent.data = {bus.imm, {EXT_W{1'b0}}};
      // Branch offset: word-aligned, the two top sign copies fall off.
      3'b011:  in_ent.data = {sext[OUT_W-3:0], 2'b00};
      3'b100:  in_ent.data = {{EXT_W{1'b1}}, bus.imm};
      default: in_ent.illegal = 1'b1;
    endcase
  end

  ext_pipe_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (bus.in_valid),
    .wr_rdy  (bus.in_ready),
    .wr_dat  (in_ent),
    .rd_vld  (bus.out_valid),
    .rd_rdy  (bus.out_ready),
    .rd_dat  (head),
    .count   (bus.count)
  );

  assign bus.out_data    = head.data;
  assign bus.out_illegal = head.illegal;
endmodule

// File: tb/tb_ext_pipe.sv
// Directed + random bench for ext_pipe with a queue-based reference model.
module tb_ext_pipe;
  localparam int IMM_W = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  logic [32:0] q[$];

  ext_pipe_if #(.IMM_W(IMM_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  ext_pipe #(.IMM_W(IMM_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Extension rules as plain integer arithmetic modulo 2^32.
  function automatic logic [32:0] ref_ext(input logic [15:0] i, input logic [2:0] op);
    longint u;
    longint s;
    longint m;
    longint r;
    u = longint'(i);
    s = (u >= 32768) ? u - 65536 : u;
    m = 64'h1_0000_0000;
    case (op)
      3'd0: r = u;
      3'd1: r = (s + m) % m;
      3'd2: r = u * 65536;
      3'd3: r = (s * 4 + m) % m;
      3'd4: r = u + (m - 65536);
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the model at negedge, then advance the model at posedge.
  task automatic step();
    bit          do_push;
    bit          do_pop;
    logic [32:0] exp;
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
    chk("count", 64'(bus.count), 64'(q.size()));
    if (q.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0][31:0]));
      chk("out_illegal", 64'(bus.out_illegal), 64'(q[0][32]));
    end
    do_push = reset_n && bus.in_valid && (q.size() < DEPTH);
    do_pop  = reset_n && bus.out_ready && (q.size() != 0);
    exp     = do_push ? ref_ext(bus.imm, bus.ext_op) : 33'h0;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(exp);
    #1;
  endtask

  task automatic push_check(input string tag, input logic [15:0] i, input logic [2:0] op,
                            input logic [31:0] exp_d, input logic exp_i);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.imm       = i;
    bus.ext_op    = op;
    step();
    bus.in_valid  = 1'b0;
    bus.imm       = 'x;
    bus.ext_op    = 'x;
    chk({tag, "_vld"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_dat"}, 64'(bus.out_data), 64'(exp_d));
    chk({tag, "_ill"}, 64'(bus.out_illegal), 64'(exp_i));
    step();
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.imm       = 'x;
    bus.ext_op    = 'x;
    #1;
    chk("rst_vld", 64'(bus.out_valid), 64'(0));
    chk("rst_rdy", 64'(bus.in_ready), 64'(1));
    chk("rst_cnt", 64'(bus.count), 64'(0));
    chk("rst_dat", 64'(bus.out_data), 64'(0));
    chk("rst_ill", 64'(bus.out_illegal), 64'(0));
    #12 reset_n = 1'b1;
    @(posedge clk); #1;

    // Extension modes on 16'h8001 and 16'h7FFF
    push_check("zero8001", 16'h8001, 3'b000, 32'h0000_8001, 1'b0);
    push_check("sign8001", 16'h8001, 3'b001, 32'hFFFF_8001, 1'b0);
    push_check("upper8001", 16'h8001, 3'b010, 32'h8001_0000, 1'b0);
    push_check("boff8001", 16'h8001, 3'b011, 32'hFFFE_0004, 1'b0);
    push_check("ones8001", 16'h8001, 3'b100, 32'hFFFF_8001, 1'b0);
    push_check("sign7fff", 16'h7FFF, 3'b001, 32'h0000_7FFF, 1'b0);
    push_check("boff7fff", 16'h7FFF, 3'b011, 32'h0001_FFFC, 1'b0);
    push_check("illegal110", 16'h1234, 3'b110, 32'h0000_0000, 1'b1);
    push_check("after_ill", 16'h0005, 3'b000, 32'h0000_0005, 1'b0);

    // Backpressure: third push refused, head held, ordered drain
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.imm    = 16'h0100 + 16'(k);
      bus.ext_op = 3'b000;
      step();
    end
    chk("full_rdy", 64'(bus.in_ready), 64'(0));
    chk("full_cnt", 64'(bus.count), 64'(2));
    chk("full_head", 64'(bus.out_data), 64'(32'h0000_0100));
    bus.in_valid = 1'b0;
    step();
    chk("held_head", 64'(bus.out_data), 64'(32'h0000_0100));
    bus.out_ready = 1'b1;
    step();
    chk("drain1_dat", 64'(bus.out_data), 64'(32'h0000_0101));
    chk("drain1_rdy", 64'(bus.in_ready), 64'(1));
    step();
    chk("drain2_vld", 64'(bus.out_valid), 64'(0));

    // Streaming: one per cycle, occupancy steady at 1, pointers wrap
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.imm    = 16'h0010 + 16'(k);
      bus.ext_op = 3'b001;
      step();
      chk("stream_cnt", 64'(bus.count), 64'(1));
    end
    bus.in_valid = 1'b0;
    step();
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.imm       = 16'($urandom_range(0, 65535));
      bus.ext_op    = 3'($urandom_range(0, 7));
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    // Reset with two entries held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.ext_op    = 3'b010;
    bus.imm       = 16'hABCD;
    step();
    bus.imm       = 16'h1357;
    step();
    bus.in_valid  = 1'b0;
    chk("pre_rst_cnt", 64'(bus.count), 64'(2));
    #3 reset_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_vld", 64'(bus.out_valid), 64'(0));
    chk("midrst_cnt", 64'(bus.count), 64'(0));
    chk("midrst_rdy", 64'(bus.in_ready), 64'(1));
    chk("midrst_dat", 64'(bus.out_data), 64'(0));
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    push_check("post_rst", 16'h8001, 3'b100, 32'hFFFF_8001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
